// File: rtl/ram_port_arbiter.sv
// Shares one RAM (combinational read port, synchronous write port) between two
// requesters. Zero-fills the RAM after reset, then runs independent round-robin
// arbiters on the read and write ports and returns registered read data.
module ram_port_arbiter #(
   parameter int unsigned depth          = 16,
   parameter int unsigned addrbits       = 4,
   parameter int unsigned width          = 10,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            req_valid,
   input  logic [1:0]            req_write,
   input  logic [2*addrbits-1:0] req_addr,
   input  logic [2*width-1:0]    req_wdata,
   output logic [1:0]            req_ready,
   output logic [1:0]            resp_valid,
   output logic [width-1:0]      resp_data,
   output logic                  init_done,
   output logic                  ram_ramin_en,
   output logic                  ram_ramin_mask,
   output logic [addrbits-1:0]   ram_ramin_addr,
   output logic [width-1:0]      ram_ramin_data,
   output logic                  ram_ramout_en,
   output logic [addrbits-1:0]   ram_ramout_addr,
   input  logic [width-1:0]      ram_ramout_data
);

   typedef enum logic [0:0] {StInit, StRun} state_e;

   localparam logic [addrbits:0] ClrLast = (addrbits + 1)'(depth - 1);

   state_e              state_q, state_d;
   logic [addrbits:0]   clr_cnt_q, clr_cnt_d;
   logic                wr_ptr_q, wr_ptr_d;
   logic                rd_ptr_q, rd_ptr_d;
   logic [1:0]          resp_valid_q;
   logic [width-1:0]    resp_data_q;
   logic                run;
   logic                clearing;
   logic [1:0]          wr_cand, rd_cand;
   logic [1:0]          wr_gnt, rd_gnt;

   // Two candidates: the pointer picks; otherwise the lone candidate (if any) wins.
   function automatic logic [1:0] rr_pick(input logic [1:0] cand, input logic ptr);
      if (cand == 2'b11) begin
         return ptr ? 2'b10 : 2'b01;
      end
      return cand;
   endfunction

   // Grants for both ports; nothing is granted while in reset or clearing.
   always_comb begin
      run      = reset && (state_q == StRun);
      clearing = reset && (state_q == StInit);
      wr_cand  = req_valid & req_write;
      rd_cand  = req_valid & ~req_write;
      wr_gnt   = run ? rr_pick(wr_cand, wr_ptr_q) : 2'b00;
      rd_gnt   = run ? rr_pick(rd_cand, rd_ptr_q) : 2'b00;
   end

   // RAM port and handshake outputs.
   always_comb begin
      req_ready       = wr_gnt | rd_gnt;
      ram_ramin_mask  = 1'b1;
      ram_ramin_en    = 1'b0;
      ram_ramin_addr  = '0;
      ram_ramin_data  = '0;
      ram_ramout_en   = 1'b0;
      ram_ramout_addr = '0;
      if (clearing) begin
         ram_ramin_en   = 1'b1;
         ram_ramin_addr = clr_cnt_q[addrbits-1:0];
      end else if (wr_gnt[0]) begin
         ram_ramin_en   = 1'b1;
         ram_ramin_addr = req_addr[0 +: addrbits];
         ram_ramin_data = req_wdata[0 +: width];
      end else if (wr_gnt[1]) begin
         ram_ramin_en   = 1'b1;
         ram_ramin_addr = req_addr[addrbits +: addrbits];
         ram_ramin_data = req_wdata[width +: width];
      end
      if (rd_gnt[0]) begin
         ram_ramout_en   = 1'b1;
         ram_ramout_addr = req_addr[0 +: addrbits];
      end else if (rd_gnt[1]) begin
         ram_ramout_en   = 1'b1;
         ram_ramout_addr = req_addr[addrbits +: addrbits];
      end
   end

   // Next-state: clear sequencing and round-robin pointer updates.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (state_q == StInit) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == ClrLast) begin
            state_d = StRun;
         end
      end
      // A grant to requester i hands priority to the other one.
      if (|wr_gnt) begin
         wr_ptr_d = wr_gnt[0];
      end
      if (|rd_gnt) begin
         rd_ptr_d = rd_gnt[0];
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= CLEAR_ON_RESET ? StInit : StRun;
         clr_cnt_q <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   // Read response register: captures the RAM output on the grant edge.
   always_ff @(posedge clock) begin
      if (!reset) begin
         resp_valid_q <= 2'b00;
         resp_data_q  <= '0;
      end else begin
         resp_valid_q <= rd_gnt;
         if (|rd_gnt) begin
            resp_data_q <= ram_ramout_data;
         end
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign init_done  = run;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Controller that shares one RAMMEM instance (1 combinational read port, 1 write port) between two requesters.
- On leaving reset it clears the memory, then arbitrates independently on the read and write ports with round-robin fairness.
- Registers read responses and returns them to the requester that issued the read.
- Sits between client logic and the RAMMEM instance; both RAMMEM clocks are tied to `clock` at the parent.

Parameters:
- depth, 16: RAM word count; must equal 2**addrbits.
- addrbits, 4: address width.
- width, 10: data width.
- CLEAR_ON_RESET, 1: 1 = zero-fill the RAM after reset; 0 = enter RUN directly.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (0 = in reset).
- req_valid  input  2  bit i = requester i has a request.
- req_write  input  2  bit i: 1 = write, 0 = read.
- req_addr  input  2*addrbits  requester i address in slice [i*addrbits +: addrbits].
- req_wdata  input  2*width  requester i write data in slice [i*width +: width].
- req_ready  output  2  bit i = request i accepted this cycle (combinational).
- resp_valid  output  2  bit i = read data for requester i valid this cycle.
- resp_data  output  width  read data; meaningful only while a resp_valid bit is set.
- init_done  output  1  high once in RUN.
- ram_ramin_en  output  1  RAM write enable.
- ram_ramin_mask  output  1  RAM write mask; constant 1.
- ram_ramin_addr  output  addrbits  RAM write address.
- ram_ramin_data  output  width  RAM write data.
- ram_ramout_en  output  1  RAM read enable.
- ram_ramout_addr  output  addrbits  RAM read address.
- ram_ramout_data  input  width  RAM combinational read data.

Behaviour:
- Reset (reset==0 at a posedge):
  - Enter INIT with clear counter 0, or RUN if CLEAR_ON_RESET==0.
  - Both round-robin pointers go to 0 (requester 0 has priority).
  - resp_valid=0, resp_data=0, init_done=0.
  - While reset is low: req_ready=0, ram_ramin_en=0, ram_ramout_en=0, RAM addresses and data = 0.
- INIT state:
  - Each cycle drive ram_ramin_en=1, ram_ramin_addr=counter, ram_ramin_data=0, then increment the counter.
  - After the write to depth-1, go to RUN. INIT lasts exactly depth cycles.
  - req_ready=0 throughout INIT; requests stay pending.
  - init_done rises on the first RUN cycle.
- RUN state: the read port and the write port are arbitrated independently, so one read and one write can be granted in the same cycle.
- Write port arbitration:
  - Candidates are requesters with req_valid & req_write.
  - A single candidate is granted. With two candidates, the one at the write pointer is granted.
  - Grant drives ram_ramin_en=1 with the granted address and data; the write lands at the same posedge.
  - After any write grant to i, the write pointer becomes 1-i.
- Read port arbitration:
  - Same scheme as the write port, with its own read pointer, over req_valid & ~req_write.
  - Grant drives ram_ramout_en=1 and ram_ramout_addr.
  - ram_ramout_data is registered into resp_data at that posedge; resp_valid[i] pulses for exactly 1 cycle. Read latency is 1 cycle.
  - There is no response backpressure.
- Handshake and idle outputs:
  - req_ready[i] = RUN & granted(i); it is combinational from req_valid and req_write.
  - A transfer occurs on req_valid[i] & req_ready[i].
  - With no grant on a port, its enable is 0 and its address and data hold 0.
- Simultaneous read and write to the same address: the read returns the pre-write contents; the new data is visible to reads from the next cycle.
- Reset mid-operation (INIT or RUN): abort immediately and drop any pending response. INIT restarts from address 0; earlier writes are not preserved semantically.
- Address width: addresses are used unmodified. The clear counter is addrbits+1 bits wide, and the terminal compare is against depth-1.

Test Plan:
- Release reset with CLEAR_ON_RESET=1, depth=16 -> ram_ramin_en high for 16 cycles with addr 0..15 and data 0; init_done rises on cycle 17; then reading every address returns 0.
- Requester 0 writes addr 3 = 0x155, then reads addr 3 -> write accepted in 1 cycle; resp_valid=2'b01 and resp_data=0x155 one cycle after the read grant.
- Both requesters hold read requests (addr 1 and addr 2) for 4 cycles after init -> grants alternate 0,1,0,1; resp_valid alternates 01,10,01,10 with the matching data.
- In the same cycle, requester 0 writes addr 5 = 0x2AA and requester 1 reads addr 5 (old value 0x011) -> both ready=1; resp_data=0x011; a read next cycle returns 0x2AA.
- Requester 1 writes addr 7 and requester 0 writes addr 8 in the same cycle with write pointer at 1 -> requester 1 is granted first, requester 0 on the next cycle; the pointer then returns to 1.
- Assert reset for 1 cycle mid-INIT (counter 9), and separately during an in-flight read -> INIT restarts at addr 0; resp_valid=0 the cycle after reset; req_ready stays 0 until init_done.
